// File: rtl/squeeze_read_sequencer.sv
// squeeze_read_sequencer: issues squeeze RAM read requests once a buffer is
// ready, absorbs the 1-cycle RAM latency and hands 3x3/1x1 words plus
// last-address/last-kernel tags to the expand engine over valid/ready.
// Optional feature macro: SQU_SEQ_STALL_CNT_EN adds stall_cnt_o[15:0].
module squeeze_read_sequencer #(
  parameter int unsigned DATA_W = 96,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned KER_W  = 10
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] tot_squ_addr_limit_i,
  input  logic [KER_W-1:0]  squ_kernals_i,
  input  logic              squ_data_ready_i,
  output logic              squ_data_req_o,
  input  logic [DATA_W-1:0] squ_3x3_data_i,
  input  logic [DATA_W-1:0] squ_1x1_data_i,
  output logic              exp_valid_o,
  input  logic              exp_ready_i,
  output logic [DATA_W-1:0] exp_3x3_data_o,
  output logic [DATA_W-1:0] exp_1x1_data_o,
  output logic              exp_last_addr_o,
  output logic              exp_last_kernal_o,
  output logic              busy_o,
`ifdef SQU_SEQ_STALL_CNT_EN
  output logic [15:0]       stall_cnt_o,
`endif
  output logic              done_o
);

  // buffer entry layout: {3x3, 1x1, last_addr, last_kernal}
  localparam int unsigned ENTRY_W = 2 * DATA_W + 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_RUN      = 2'd2,
    ST_DRAIN    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   limit_q, limit_d;
  logic [KER_W-1:0]    kernals_q, kernals_d;
  logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic [KER_W-1:0]    ker_cnt_q, ker_cnt_d;
  logic                inflight_q, inflight_d;
  logic                infl_last_addr_q, infl_last_addr_d;
  logic                infl_last_ker_q, infl_last_ker_d;
  logic [ENTRY_W-1:0]  mem_q [2];
  logic [ENTRY_W-1:0]  mem_d [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          occ_q, occ_d;

  logic [2:0]          fill_c;
  logic                pop_c;
  logic                addr_wrap_c;
  logic                ker_last_c;
  logic                final_req_c;
  logic [ENTRY_W-1:0]  head_c;

  // Occupancy plus the beat still inside the RAM bounds how many more reads are safe
  assign fill_c      = 3'(occ_q) + 3'(inflight_q);
  assign pop_c       = (occ_q != 2'd0) && exp_ready_i;
  assign addr_wrap_c = (addr_cnt_q == limit_q);
  assign ker_last_c  = (ker_cnt_q == kernals_q);
  assign final_req_c = squ_data_req_o && addr_wrap_c && ker_last_c;

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; start_i aborts from anywhere
  always_comb begin
    state_d = state_q;
    if (start_i) begin
      state_d = ST_WAIT_RDY;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = ST_IDLE;
        ST_WAIT_RDY: if (squ_data_ready_i) state_d = ST_RUN;
        ST_RUN:      if (final_req_c) state_d = ST_DRAIN;
        ST_DRAIN:    if (!inflight_q && ((occ_q == 2'd0) ||
                                         ((occ_q == 2'd1) && pop_c)))
                       state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs; requests never look at exp_ready_i
  always_comb begin
    squ_data_req_o = 1'b0;
    done_o         = 1'b0;
    busy_o         = (state_q != ST_IDLE);
    if (state_q == ST_RUN)
      squ_data_req_o = squ_data_ready_i && (fill_c < 3'd2);
    if ((state_q == ST_DRAIN) && !inflight_q && (occ_q == 2'd1) && exp_ready_i)
      done_o = 1'b1;
  end

  // Counters, in-flight tag pipe and 2-entry output buffer next values
  always_comb begin
    limit_d          = limit_q;
    kernals_d        = kernals_q;
    addr_cnt_d       = addr_cnt_q;
    ker_cnt_d        = ker_cnt_q;
    inflight_d       = inflight_q;
    infl_last_addr_d = infl_last_addr_q;
    infl_last_ker_d  = infl_last_ker_q;
    mem_d            = mem_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    occ_d            = occ_q;
    if (start_i) begin
      limit_d          = tot_squ_addr_limit_i;
      kernals_d        = squ_kernals_i;
      addr_cnt_d       = '0;
      ker_cnt_d        = '0;
      inflight_d       = 1'b0;
      infl_last_addr_d = 1'b0;
      infl_last_ker_d  = 1'b0;
      wr_ptr_d         = 1'b0;
      rd_ptr_d         = 1'b0;
      occ_d            = 2'd0;
    end else begin
      inflight_d = squ_data_req_o;
      if (squ_data_req_o) begin
        infl_last_addr_d = addr_wrap_c;
        infl_last_ker_d  = ker_last_c;
        if (addr_wrap_c) begin
          addr_cnt_d = '0;
          ker_cnt_d  = ker_cnt_q + KER_W'(1);
        end else begin
          addr_cnt_d = addr_cnt_q + ADDR_W'(1);
        end
      end
      if (inflight_q) begin
        mem_d[wr_ptr_q] = {squ_3x3_data_i, squ_1x1_data_i,
                           infl_last_addr_q, infl_last_ker_q};
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_c) rd_ptr_d = ~rd_ptr_q;
      occ_d = occ_q + 2'(inflight_q) - 2'(pop_c);
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      limit_q          <= '0;
      kernals_q        <= '0;
      addr_cnt_q       <= '0;
      ker_cnt_q        <= '0;
      inflight_q       <= 1'b0;
      infl_last_addr_q <= 1'b0;
      infl_last_ker_q  <= 1'b0;
      mem_q[0]         <= '0;
      mem_q[1]         <= '0;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      occ_q            <= 2'd0;
    end else begin
      limit_q          <= limit_d;
      kernals_q        <= kernals_d;
      addr_cnt_q       <= addr_cnt_d;
      ker_cnt_q        <= ker_cnt_d;
      inflight_q       <= inflight_d;
      infl_last_addr_q <= infl_last_addr_d;
      infl_last_ker_q  <= infl_last_ker_d;
      mem_q[0]         <= mem_d[0];
      mem_q[1]         <= mem_d[1];
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      occ_q            <= occ_d;
    end
  end

  // Expand-side outputs come straight from the buffer head
  assign head_c            = mem_q[rd_ptr_q];
  assign exp_valid_o       = (occ_q != 2'd0);
  assign exp_3x3_data_o    = head_c[ENTRY_W-1 -: DATA_W];
  assign exp_1x1_data_o    = head_c[2 +: DATA_W];
  assign exp_last_addr_o   = head_c[1];
  assign exp_last_kernal_o = head_c[0];

`ifdef SQU_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of backpressured cycles during a pass
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (start_i)
      stall_cnt_d = 16'h0000;
    else if (busy_o && exp_valid_o && !exp_ready_i && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall counter register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) stall_cnt_q <= 16'h0000;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_squeeze_read_sequencer.sv
// Self-checking bench for squeeze_read_sequencer: table of pass configs plus
// hand-written abort and async-reset sequences. A small RAM model answers
// each request one cycle later with a word tagged by pass and address index.
module tb_squeeze_read_sequencer;

  localparam int unsigned DATA_W = 96;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned KER_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n_i;
  logic              start_i;
  logic [ADDR_W-1:0] tot_squ_addr_limit_i;
  logic [KER_W-1:0]  squ_kernals_i;
  logic              squ_data_ready_i;
  logic              squ_data_req_o;
  logic [DATA_W-1:0] squ_3x3_data_i;
  logic [DATA_W-1:0] squ_1x1_data_i;
  logic              exp_valid_o;
  logic              exp_ready_i;
  logic [DATA_W-1:0] exp_3x3_data_o;
  logic [DATA_W-1:0] exp_1x1_data_o;
  logic              exp_last_addr_o;
  logic              exp_last_kernal_o;
  logic              busy_o;
  logic              done_o;
`ifdef SQU_SEQ_STALL_CNT_EN
  logic [15:0]       stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int pass_id = 0;
  int ram_idx = 0;

  always #5 clk = ~clk;

  squeeze_read_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .KER_W(KER_W)) dut (
    .clk_i                (clk),
    .rst_n_i              (rst_n_i),
    .start_i              (start_i),
    .tot_squ_addr_limit_i (tot_squ_addr_limit_i),
    .squ_kernals_i        (squ_kernals_i),
    .squ_data_ready_i     (squ_data_ready_i),
    .squ_data_req_o       (squ_data_req_o),
    .squ_3x3_data_i       (squ_3x3_data_i),
    .squ_1x1_data_i       (squ_1x1_data_i),
    .exp_valid_o          (exp_valid_o),
    .exp_ready_i          (exp_ready_i),
    .exp_3x3_data_o       (exp_3x3_data_o),
    .exp_1x1_data_o       (exp_1x1_data_o),
    .exp_last_addr_o      (exp_last_addr_o),
    .exp_last_kernal_o    (exp_last_kernal_o),
    .busy_o               (busy_o),
`ifdef SQU_SEQ_STALL_CNT_EN
    .stall_cnt_o          (stall_cnt_o),
`endif
    .done_o               (done_o)
  );

  function automatic logic [95:0] w3(input int p, input int i);
    return {32'(p), 32'(i), 32'hC0DE0033};
  endfunction

  function automatic logic [95:0] w1(input int p, input int i);
    return {32'(i) ^ 32'hFFFF_FFFF, 32'(p), 32'h0000_1111};
  endfunction

  // RAM model: data for a request appears one cycle later; a request made
  // in a start cycle returns junk that must never reach the output
  always @(posedge clk) begin
    if (squ_data_req_o) begin
      if (start_i) begin
        squ_3x3_data_i <= '1;
        squ_1x1_data_i <= '1;
      end else begin
        squ_3x3_data_i <= w3(pass_id, ram_idx);
        squ_1x1_data_i <= w1(pass_id, ram_idx);
      end
    end
    if (start_i)             ram_idx <= 0;
    else if (squ_data_req_o) ram_idx <= ram_idx + 1;
  end

  task automatic check(input string name, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    int lim;      // address limit (beats per kernel - 1)
    int ker;      // kernel passes - 1
    int rmode;    // 0: exp_ready always 1, 1: one cycle on / two off
    int sqdly;    // cycles squ_data_ready_i held low after start
    int nbeats;   // expected beats
    int frq;      // expected cycle (start = 0) of the first request
  } vec_t;

  vec_t vecs[5];

  // One pass: start, then monitor every cycle; abort_after > 0 stops early
  task automatic run_pass(input vec_t v, input int abort_after);
    int total, beats, outst, viol, stab, first_req, stalls;
    bit finished, post, hs;
    logic [193:0] held, head;
    logic held_v;
    logic exp_la, exp_lk, exp_done;
    total = (v.lim + 1) * (v.ker + 1);
    beats = 0; outst = 0; viol = 0; stab = 0; first_req = -1; stalls = 0;
    finished = 0; post = 0; held_v = 1'b0; held = '0;
    pass_id++;
    @(posedge clk); #1;
    start_i              = 1'b1;
    tot_squ_addr_limit_i = ADDR_W'(v.lim);
    squ_kernals_i        = KER_W'(v.ker);
    squ_data_ready_i     = (v.sqdly == 0);
    exp_ready_i          = 1'b1;
    @(negedge clk);
    check("start_cycle_no_done", done_o, 1'b0);
    for (int c = 1; c < 600 && !finished; c++) begin
      @(posedge clk); #1;
      start_i          = 1'b0;
      squ_data_ready_i = (c >= v.sqdly);
      exp_ready_i      = (v.rmode == 0) ? 1'b1 : ((c % 3) == 0);
      @(negedge clk);
      if (post) begin
        check("idle_after_done", {busy_o, exp_valid_o, squ_data_req_o}, 3'b000);
`ifdef SQU_SEQ_STALL_CNT_EN
        check("stall_cnt", stall_cnt_o, 16'(stalls));
`endif
        finished = 1;
      end else begin
        head = {exp_3x3_data_o, exp_1x1_data_o, exp_last_addr_o, exp_last_kernal_o};
        if (squ_data_req_o) begin
          if (first_req < 0) first_req = c;
          if (outst >= 2) viol++;
        end
        if (held_v && exp_valid_o && (head !== held)) stab++;
        hs = exp_valid_o && exp_ready_i;
        if (hs) begin
          exp_la   = ((beats % (v.lim + 1)) == v.lim);
          exp_lk   = ((beats / (v.lim + 1)) == v.ker);
          exp_done = (abort_after == 0) && (beats == total - 1);
          check("beat", {head, done_o},
                {w3(pass_id, beats), w1(pass_id, beats), exp_la, exp_lk, exp_done});
          beats++;
        end else if (done_o) begin
          check("stray_done", done_o, 1'b0);
        end
        if (busy_o && exp_valid_o && !exp_ready_i) stalls++;
        held_v = exp_valid_o && !exp_ready_i;
        held   = head;
        outst  = outst + int'(squ_data_req_o) - int'(hs);
        if (abort_after > 0 && beats == abort_after) finished = 1;
        else if (abort_after == 0 && beats == total) post = 1;
      end
    end
    check("pass_completed", finished, 1'b1);
    check("req_while_full", viol, 0);
    if (abort_after == 0) begin
      check("beat_count", beats, v.nbeats);
      check("head_stable", stab, 0);
      check("first_req_cycle", first_req, v.frq);
    end
  endtask

  initial begin
    vecs[0] = '{lim: 3, ker: 1, rmode: 0, sqdly: 0, nbeats: 8, frq: 2};
    vecs[1] = '{lim: 7, ker: 0, rmode: 1, sqdly: 0, nbeats: 8, frq: 2};
    vecs[2] = '{lim: 0, ker: 2, rmode: 0, sqdly: 0, nbeats: 3, frq: 2};
    vecs[3] = '{lim: 2, ker: 0, rmode: 0, sqdly: 5, nbeats: 3, frq: 6};
    vecs[4] = '{lim: 1, ker: 1, rmode: 1, sqdly: 0, nbeats: 4, frq: 2};

    rst_n_i = 1'b0; start_i = 1'b0; tot_squ_addr_limit_i = '0; squ_kernals_i = '0;
    squ_data_ready_i = 1'b0; exp_ready_i = 1'b0;
    squ_3x3_data_i = '0; squ_1x1_data_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {squ_data_req_o, exp_valid_o, exp_3x3_data_o, exp_1x1_data_o,
           exp_last_addr_o, exp_last_kernal_o, busy_o, done_o}, '0);
`ifdef SQU_SEQ_STALL_CNT_EN
    check("reset_stall_cnt", stall_cnt_o, 16'h0);
`endif
    @(posedge clk); #1 rst_n_i = 1'b1;

    for (int i = 0; i < 5; i++) run_pass(vecs[i], 0);

    // Abort mid-RUN after three beats, then a short replacement pass
    run_pass('{lim: 3, ker: 1, rmode: 0, sqdly: 0, nbeats: 8, frq: 2}, 3);
    run_pass('{lim: 1, ker: 0, rmode: 0, sqdly: 0, nbeats: 2, frq: 2}, 0);

    // Async reset while in DRAIN with the buffer full and backpressured
    pass_id++;
    @(posedge clk); #1;
    start_i = 1'b1; tot_squ_addr_limit_i = ADDR_W'(1); squ_kernals_i = KER_W'(0);
    squ_data_ready_i = 1'b1; exp_ready_i = 1'b0;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("drain_held", {busy_o, exp_valid_o, squ_data_req_o}, 3'b110);
    #2 rst_n_i = 1'b0;
    #1;
    check("async_reset_outputs",
          {squ_data_req_o, exp_valid_o, exp_3x3_data_o, exp_1x1_data_o,
           exp_last_addr_o, exp_last_kernal_o, busy_o, done_o}, '0);
`ifdef SQU_SEQ_STALL_CNT_EN
    check("async_reset_stall_cnt", stall_cnt_o, 16'h0);
`endif
    @(posedge clk); #2 rst_n_i = 1'b1;
    exp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_until_start", {busy_o, exp_valid_o, squ_data_req_o, done_o}, 4'b0000);
    end
    run_pass(vecs[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
